opti_divider: RTL and testbench

OPTI_DIVIDER -- requirements
Module: opti_divider

---
 rtl/opti_divider.sv | 143 ++++++++++++++
 tb/tb_opti_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/opti_divider.sv
// Signed fixed-point divider: q = a / b.
// Restoring division with one quotient bit per cycle, fixed latency, and
// saturation on overflow or a zero divisor.
//
// state | meaning
// IDLE  | waiting for an operand pair, ready_in high
// CALC  | W restoring-division steps, quotient magnitude built MSB-first
// FIX   | sign/saturation applied, result registered, valid_out raised
module opti_divider #(
   parameter int W    = 24,
   parameter int FRAC = 22
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         valid_in,
   output logic         ready_in,
   output logic [W-1:0] q,
   output logic         valid_out,
   output logic         ovf,
   output logic         div0
);

   localparam int NW = W + FRAC;      // numerator |a| * 2^FRAC
   localparam int SH = W - 1 - FRAC;  // ovf threshold exponent
   localparam int PW = W + SH;        // width of |b| * 2^SH

   localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [W-1:0]  abs_a, abs_b;
   logic [PW-1:0] a_ext, b_scaled;
   logic          ovf_pred, div0_pred, accept;

   logic          sign_q, sign_a, ovf_r, div0_r;
   logic [W-1:0]  dvsr;
   logic [NW-1:0] num;
   logic [NW-1:0] rem;
   logic [W-1:0]  qm;
   logic [W-1:0]  cnt;

   logic [NW-1:0] rem_base;
   logic [NW:0]   rem_sh, rem_nxt, dvsr_ext;
   logic          q_bit;

   assign ready_in = (state == IDLE);
   assign accept   = valid_in && ready_in;

   // Magnitudes; the most negative value maps to 2^(W-1) exactly.
   assign abs_a     = a[W-1] ? (~a + 1'b1) : a;
   assign abs_b     = b[W-1] ? (~b + 1'b1) : b;
   assign a_ext     = PW'(abs_a);
   assign b_scaled  = PW'(abs_b) << SH;
   assign div0_pred = (b == '0);
   assign ovf_pred  = !div0_pred && (a_ext >= b_scaled);

   // The first step seeds the remainder with the numerator bits above the W
   // quotient positions; any quotient bit there would already mean overflow.
   assign rem_base = (cnt == '0) ? NW'(num[NW-1:W]) : rem;
   assign rem_sh   = {rem_base, num[W-1]};
   assign dvsr_ext = (NW+1)'(dvsr);
   assign q_bit    = (rem_sh >= dvsr_ext);
   assign rem_nxt  = q_bit ? (rem_sh - dvsr_ext) : rem_sh;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (cnt == W'(W-1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture and the per-cycle restoring step.
   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
         sign_a <= 1'b0;
         ovf_r  <= 1'b0;
         div0_r <= 1'b0;
         dvsr   <= '0;
         num    <= '0;
         rem    <= '0;
         qm     <= '0;
         cnt    <= '0;
      end else if (state == IDLE) begin
         if (accept) begin
            sign_q <= a[W-1] ^ b[W-1];
            sign_a <= a[W-1];
            ovf_r  <= ovf_pred;
            div0_r <= div0_pred;
            dvsr   <= abs_b;
            num    <= {abs_a, {FRAC{1'b0}}};
            rem    <= '0;
            qm     <= '0;
            cnt    <= '0;
         end
      end else if (state == CALC) begin
         rem <= NW'(rem_nxt);
         qm  <= {qm[W-2:0], q_bit};
         num <= num << 1;
         cnt <= cnt + 1'b1;
      end
   end

   // Result register: saturation priority is div0, then ovf, then signed Qm.
   always_ff @(posedge clk) begin
      if (rst) begin
         q         <= '0;
         ovf       <= 1'b0;
         div0      <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (state == FIX) begin
            valid_out <= 1'b1;
            ovf       <= ovf_r;
            div0      <= div0_r;
            if (div0_r)     q <= sign_a ? Q_MIN : Q_MAX;
            else if (ovf_r) q <= sign_q ? Q_MIN : Q_MAX;
            else            q <= sign_q ? (~qm + 1'b1) : qm;
         end
      end
   end

endmodule

// File: tb/tb_opti_divider.sv
// Directed bench for opti_divider: vector table plus back-to-back and
// mid-calculation reset sequences.
module tb_opti_divider;

   localparam int W = 24;

   logic         clk;
   logic         rst;
   logic [W-1:0] a, b;
   logic         valid_in;
   logic         ready_in;
   logic [W-1:0] q;
   logic         valid_out;
   logic         ovf;
   logic         div0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic         ovf;
      logic         div0;
   } vec_t;

   vec_t vecs[16];

   opti_divider #(.W(24), .FRAC(22)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .q         (q),
      .valid_out (valid_out),
      .ovf       (ovf),
      .div0      (div0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int k;
      for (k = 0; k < 60; k++) begin
         if (ready_in) break;
         tick();
      end
      if (k == 60) chk({name, "_ready_timeout"}, 32'(ready_in), 32'd1);
   endtask

   task automatic run_one(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] eq, input logic eovf, input logic ediv0);
      int lat;
      wait_ready(name);
      a = va;
      b = vb;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      lat = 0;
      for (int k = 1; k <= W + 3; k++) begin
         tick();
         if (valid_out) begin
            lat = k;
            break;
         end
      end
      chk({name, "_latency"}, 32'(lat), 32'(W + 1));
      chk({name, "_q"}, 32'(q), 32'(eq));
      chk({name, "_ovf"}, 32'(ovf), 32'(eovf));
      chk({name, "_div0"}, 32'(div0), 32'(ediv0));
      chk({name, "_ready_with_valid"}, 32'(ready_in), 32'd1);
      tick();
      chk({name, "_pulse_len"}, 32'(valid_out), 32'd0);
      chk({name, "_q_hold"}, 32'(q), 32'(eq));
   endtask

   initial begin
      int lat, seen;

      vecs[0]  = '{a: 24'h200000, b: 24'h400000, q: 24'h200000, ovf: 1'b0, div0: 1'b0};
      vecs[1]  = '{a: 24'h400000, b: 24'h600000, q: 24'h2AAAAA, ovf: 1'b0, div0: 1'b0};
      vecs[2]  = '{a: 24'hD00000, b: 24'h600000, q: 24'hE00000, ovf: 1'b0, div0: 1'b0};
      vecs[3]  = '{a: 24'h400000, b: 24'h200000, q: 24'h7FFFFF, ovf: 1'b1, div0: 1'b0};
      vecs[4]  = '{a: 24'hC00000, b: 24'h200000, q: 24'h800000, ovf: 1'b1, div0: 1'b0};
      vecs[5]  = '{a: 24'hC00000, b: 24'h000000, q: 24'h800000, ovf: 1'b0, div0: 1'b1};
      vecs[6]  = '{a: 24'h000000, b: 24'h000000, q: 24'h7FFFFF, ovf: 1'b0, div0: 1'b1};
      vecs[7]  = '{a: 24'h800000, b: 24'hC00000, q: 24'h7FFFFF, ovf: 1'b1, div0: 1'b0};
      vecs[8]  = '{a: 24'h800000, b: 24'h800000, q: 24'h400000, ovf: 1'b0, div0: 1'b0};
      vecs[9]  = '{a: 24'h100000, b: 24'hF00000, q: 24'hC00000, ovf: 1'b0, div0: 1'b0};
      vecs[10] = '{a: 24'h000001, b: 24'h400000, q: 24'h000001, ovf: 1'b0, div0: 1'b0};
      vecs[11] = '{a: 24'hFFFFFF, b: 24'h7FFFFF, q: 24'h000000, ovf: 1'b0, div0: 1'b0};
      vecs[12] = '{a: 24'h3FFFFF, b: 24'h200000, q: 24'h7FFFFE, ovf: 1'b0, div0: 1'b0};
      vecs[13] = '{a: 24'h7FFFFF, b: 24'h000000, q: 24'h7FFFFF, ovf: 1'b0, div0: 1'b1};
      vecs[14] = '{a: 24'h000000, b: 24'h400000, q: 24'h000000, ovf: 1'b0, div0: 1'b0};
      vecs[15] = '{a: 24'h7FFFFF, b: 24'hC00000, q: 24'h800001, ovf: 1'b0, div0: 1'b0};

      // Reset with valid_in held high: nothing may be accepted.
      rst = 1'b1;
      valid_in = 1'b1;
      a = 24'h400000;
      b = 24'h200000;
      repeat (3) tick();
      rst = 1'b0;
      valid_in = 1'b0;
      chk("rst_ready", 32'(ready_in), 32'd1);
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_div0", 32'(div0), 32'd0);

      foreach (vecs[i])
         run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].ovf, vecs[i].div0);

      // Back-to-back: second pair held on valid_in throughout CALC.
      wait_ready("b2b");
      a = 24'h200000;
      b = 24'h400000;
      valid_in = 1'b1;
      tick();
      a = 24'h400000;
      b = 24'h600000;
      chk("b2b_busy_ready", 32'(ready_in), 32'd0);
      lat = 0;
      for (int k = 1; k <= W + 3; k++) begin
         tick();
         if (valid_out) begin
            lat = k;
            break;
         end
      end
      chk("b2b_first_latency", 32'(lat), 32'(W + 1));
      chk("b2b_first_q", 32'(q), 32'h200000);
      chk("b2b_first_ready", 32'(ready_in), 32'd1);
      tick();
      valid_in = 1'b0;
      chk("b2b_second_accepted", 32'(ready_in), 32'd0);
      lat = 0;
      for (int k = 2; k <= W + 5; k++) begin
         tick();
         if (valid_out) begin
            lat = k;
            break;
         end
      end
      chk("b2b_spacing", 32'(lat), 32'(W + 2));
      chk("b2b_second_q", 32'(q), 32'h2AAAAA);

      // Leave nonzero outputs and a set flag, then abort a request mid-CALC.
      run_one("pre_abort", 24'hC00000, 24'h000000, 24'h800000, 1'b0, 1'b1);
      wait_ready("abort");
      a = 24'h400000;
      b = 24'h600000;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (10) tick();
      chk("abort_in_calc", 32'(ready_in), 32'd0);
      rst = 1'b1;
      valid_in = 1'b1;
      a = 24'h200000;
      b = 24'h400000;
      tick();
      rst = 1'b0;
      valid_in = 1'b0;
      chk("abort_ready", 32'(ready_in), 32'd1);
      chk("abort_q", 32'(q), 32'd0);
      chk("abort_div0", 32'(div0), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      chk("abort_valid_out", 32'(valid_out), 32'd0);
      seen = 0;
      for (int k = 0; k < W + 6; k++) begin
         tick();
         if (valid_out) seen++;
      end
      chk("abort_no_valid_out", 32'(seen), 32'd0);
      run_one("post_abort", 24'hD00000, 24'h600000, 24'hE00000, 1'b0, 1'b0);
      run_one("post_abort_ovf", 24'hC00000, 24'h200000, 24'h800000, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
